// File: rtl/joy_pkg.sv
// Shared frame definition for the joystick serial link, used by transmitter and receiver.
package joy_pkg;

  localparam int JOY_FRAME_BITS = 24;
  localparam int JOY_BTN_W      = 12;

  // Slot i carries btn2 when SLOT_P2[i] is set, otherwise btn1, at bit SLOT_BIT[i].
  localparam logic [JOY_FRAME_BITS-1:0] SLOT_P2 = 24'h0F_FF00;

  localparam logic [3:0] SLOT_BIT [JOY_FRAME_BITS] = '{
    4'd8,  4'd6,  4'd5, 4'd4, 4'd3,  4'd2,  4'd1, 4'd0,
    4'd8,  4'd6,  4'd5, 4'd4, 4'd3,  4'd2,  4'd1, 4'd0,
    4'd10, 4'd11, 4'd9, 4'd7, 4'd10, 4'd11, 4'd9, 4'd7
  };

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } joy_state_e;

  function automatic logic [JOY_FRAME_BITS-1:0] joy_build_frame(
    input logic [JOY_BTN_W-1:0] b1,
    input logic [JOY_BTN_W-1:0] b2
  );
    logic [JOY_FRAME_BITS-1:0] f;
    f = '1;
    for (int i = 0; i < JOY_FRAME_BITS; i++) begin
      f[i] = SLOT_P2[i] ? b2[SLOT_BIT[i]] : b1[SLOT_BIT[i]];
    end
    return f;
  endfunction

endpackage

// File: rtl/joy_serial_tx_if.sv
// Reader-side joystick serial link: shift clock and load strobe in, serial data back.
interface joy_serial_tx_if;

  logic joy_clk_in;
  logic joy_load_in;
  logic joy_data_out;

  modport master (
    output joy_clk_in,
    output joy_load_in,
    input  joy_data_out
  );

  modport slave (
    input  joy_clk_in,
    input  joy_load_in,
    output joy_data_out
  );

endinterface

// File: rtl/joy_sync.sv
// Single-bit flop-chain synchronizer into clk12; resets to RESET_VAL so idle-high lines stay quiet.
module joy_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk12,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk12 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/joy_serial_tx.sv
// Joystick serial transmitter: snapshots both button vectors on a load edge and
// shifts one slot per reader clock edge back on joy_data_out.
//
//   state    | meaning
//   ST_IDLE  | pointer parked at FRAME_BITS, data held at 1, shift edges ignored
//   ST_SHIFT | pointer < FRAME_BITS, each shift edge advances one slot
module joy_serial_tx
  import joy_pkg::*;
#(
  parameter int FRAME_BITS   = JOY_FRAME_BITS,
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 4096
) (
  input  logic                 clk12,
  input  logic                 rst_n,
  joy_serial_tx_if.slave       link,
  input  logic [JOY_BTN_W-1:0] btn1,
  input  logic [JOY_BTN_W-1:0] btn2,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic                 link_idle
);

  localparam int PTR_W  = $clog2(FRAME_BITS + 1);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [PTR_W-1:0]  PTR_END  = PTR_W'(FRAME_BITS);
  localparam logic [IDLE_W-1:0] IDLE_END = IDLE_W'(IDLE_TIMEOUT);

  logic                 clk_s;
  logic                 clk_d;
  logic                 load_s;
  logic [JOY_BTN_W-1:0] btn1_s;
  logic [JOY_BTN_W-1:0] btn2_s;
  logic                 clk_rise;
  logic                 load_edge;
  logic                 shift_edge;

  joy_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_clk (
    .clk12 (clk12),
    .rst_n (rst_n),
    .d     (link.joy_clk_in),
    .q     (clk_s)
  );

  joy_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_load (
    .clk12 (clk12),
    .rst_n (rst_n),
    .d     (link.joy_load_in),
    .q     (load_s)
  );

  for (genvar i = 0; i < JOY_BTN_W; i++) begin : g_btn_sync
    joy_sync #(.STAGES(2), .RESET_VAL(1'b1)) u_sync_b1 (
      .clk12 (clk12),
      .rst_n (rst_n),
      .d     (btn1[i]),
      .q     (btn1_s[i])
    );
    joy_sync #(.STAGES(2), .RESET_VAL(1'b1)) u_sync_b2 (
      .clk12 (clk12),
      .rst_n (rst_n),
      .d     (btn2[i]),
      .q     (btn2_s[i])
    );
  end

  always_ff @(posedge clk12 or negedge rst_n) begin
    if (!rst_n) begin
      clk_d <= 1'b1;
    end else begin
      clk_d <= clk_s;
    end
  end

  assign clk_rise   = clk_s & ~clk_d;
  assign load_edge  = clk_rise & ~load_s;
  assign shift_edge = clk_rise &  load_s;

  joy_state_e                state_q, state_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic [JOY_FRAME_BITS-1:0] snap_q, snap_d;
  logic                      data_q, data_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  always_ff @(posedge clk12 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= PTR_END;
      snap_q  <= '1;
      data_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      snap_q  <= snap_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    snap_d  = snap_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (load_edge) begin
      // A load with slot 0 already out is a clean re-sync, not an aborted frame.
      err_d   = (state_q == ST_SHIFT) && (ptr_q != '0);
      snap_d  = joy_build_frame(btn1_s, btn2_s);
      ptr_d   = '0;
      data_d  = snap_d[0];
      state_d = ST_SHIFT;
    end else if (shift_edge && (state_q == ST_SHIFT)) begin
      ptr_d = ptr_q + 1'b1;
      if ((ptr_d == PTR_END) || (int'(ptr_d) >= JOY_FRAME_BITS)) begin
        data_d = 1'b1;
      end else begin
        data_d = snap_q[ptr_d];
      end
      if (ptr_d == PTR_END) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  logic [IDLE_W-1:0] idle_cnt_q;

  always_ff @(posedge clk12 or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= '0;
    end else if (clk_rise) begin
      idle_cnt_q <= '0;
    end else if (idle_cnt_q != IDLE_END) begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end
  end

  assign link_idle         = (idle_cnt_q == IDLE_END);
  assign link.joy_data_out = data_q;
  assign frame_done        = done_q;
  assign frame_err         = err_q;

endmodule
